mul_red_pipe: RTL
=================

// Module: mul_red_pipe
// PURPOSE
//  Parametrised, stall-capable successor of the unified Kyber/Dilithium multiply-reduce unit.
//  - Kyber mode: two 12x12 products, each reduced mod KQ.
//  - Dilithium mode: one recombined product reduced mod DQ.
//  - Adds valid/ready flow control, a per-beat mode/sel tag and parameterised operand-alignment delays.
//  - Sits between the butterfly operand muxes and the PE add/sub stage.
// PARAMETERS
//  KQ          3329     Kyber modulus
//  DQ          8380417  Dilithium modulus
//  RED_STAGES  1        internal pipeline stages of each reducer (1..3)
//  DLY_K4N_AH  4        A_high delay, sel_a=K4_NTT
//  DLY_K4N_WH  5        w_high delay, sel_a=K4_NTT
//  DLY_K4N_WL  4        w_low delay, sel_a=K4_NTT
//  DLY_K4I_AH  2        A_high delay, sel_a=K4_INTT
// PORTS
//  clk           in   1   clock
//  rst           in   1   asynchronous, active-high reset
//  in_valid      in   1   operand beat valid
//  in_ready      out  1   unit can accept/advance this cycle
//  A             in   24  {A_high,A_low}
//  w             in   24  {w_high,w_low}
//  mul_red_mode  in   1   0=Kyber dual lane, 1=Dilithium
//  sel_a         in   2   0=K2_NTT 1=K4_NTT 2=K4_INTT 3=K2_INTT
//  out_valid     out  1   result valid
//  out_ready     in   1   downstream accepts result
//  result        out  24  reduced result
//  range_err     out  1   only with MUL_RED_RANGE_CHK_EN
// BEHAVIOUR
//  - Reset: all valid bits, delay lines, pipeline registers, result and range_err = 0.
//    Reset asserted mid-stream drops in-flight beats immediately.
//  - Advance: en = ~(out_valid & ~out_ready); in_ready = en.
//    Every register, including the delay lines, updates only when en=1.
//    A beat is accepted when in_valid & in_ready.
//  - Alignment: delay lines sample A/w on every en cycle regardless of in_valid.
//    Operand select uses the sel_a of the current cycle.
//    sel_a=1: A_high, w_high, w_low taken DLY_K4N_* advances back.
//    sel_a=2: A_high taken DLY_K4I_AH advances back.
//    Otherwise undelayed. A_low is never delayed.
//  - Pipeline: S1 registers P1=A_high*w_high and P0=A_low*w_low (24b each), plus mode tag.
//    S2 registers S = P1*2^24 + P0*2^12 (48b); P1/P0 pass through.
//    Then RED_STAGES reduction stages, then the output register.
//  - Latency: 3+RED_STAGES advancing cycles from acceptance to out_valid (4 by default).
//    Identical for both modes; beats stay in order.
//  - Results:
//    mode 0: result = {P1 mod KQ, P0 mod KQ}, each lane in [0,KQ).
//    mode 1: result = {1'b0, S mod DQ}, in [0,DQ).
//  - Mode and sel_a may change on any beat; each beat is processed with its own tag.
//    No flush is required between modes.
//  - Bubbles (in_valid=0) carry valid=0; result holds its last value while out_valid=0.
//  - Stalled output: result stays stable and out_valid stays high until out_ready=1.
// CONFIGURATION
//  - MUL_RED_RANGE_CHK_EN defined: adds range_err, pipelined alongside the beat.
//    Mode 0: set when any 12-bit operand half >= KQ.
//    Mode 1: set when {A_high,A_low} or {w_high,w_low} >= DQ.
//    Valid only with out_valid.
//  - Undefined: port and logic are absent. No other behaviour changes.
// STRUCTURE
//  - mul_red_pkg: KQ/DQ defaults, sel_a encodings (SEL_K2_NTT..SEL_K2_INTT), mode encodings.
//  - Sub-module mul_red_dly(WIDTH, DEPTH): enable-gated shift-register delay line with async reset.
//  - Reducers: the existing K_redu/D_redu, wrapped for RED_STAGES.
// TESTING
//  1. Kyber, sel 0: A={3328,2}, w={3328,1664}, out_ready=1.
//     -> result=24'h001D00 four cycles after acceptance.
//  2. Dilithium: A={1,0}, w={1,0}.
//     -> result=24'h003FFE (2^24 mod DQ=16382).
//  3. Stream of 6 beats with out_ready=0 for cycles 5..7.
//     -> in_ready=0 during the stall, no loss or duplication, order kept, result stable while stalled.
//  4. sel_a=1, A_high=n and w_high=n on the n-th advance, w_low=A_low=1.
//     -> high lane = (n-4)(n-5) mod KQ.
//  5. rst pulsed with 3 beats in flight.
//     -> out_valid=0 and result=0 asynchronously; next beat has 4-cycle latency.
//  6. MUL_RED_RANGE_CHK_EN, mode 0, A_low=3329.
//     -> range_err=1 with that beat only; neighbouring beats show 0.

Source files
------------

// File: rtl/mul_red_pkg.sv
// ============================================================================
//  Module   : mul_red_pkg
//  Purpose  : Shared constants and encodings for the Kyber/Dilithium
//             multiply-reduce pipeline: default moduli, sel_a operand
//             alignment encodings and the lane-mode encoding.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_red_pkg;

    // Default moduli
    localparam int KQ_DEFAULT = 3329;
    localparam int DQ_DEFAULT = 8380417;

    // Operand-alignment selector: which butterfly flavour feeds this beat
    typedef enum logic [1:0] {
        SEL_K2_NTT  = 2'd0,
        SEL_K4_NTT  = 2'd1,
        SEL_K4_INTT = 2'd2,
        SEL_K2_INTT = 2'd3
    } sel_e;

    // Lane mode: two independent 12-bit Kyber lanes, or one Dilithium word
    typedef enum logic {
        MODE_KYBER = 1'b0,
        MODE_DIL   = 1'b1
    } mode_e;

endpackage : mul_red_pkg

`default_nettype wire

// File: rtl/mul_red_pipe_if.sv
// ============================================================================
//  Module   : mul_red_pipe_if
//  Purpose  : Valid/ready operand and result bundle of mul_red_pipe.
//  Signals  : in_valid/in_ready, A, w, mul_red_mode, sel_a   (operand side)
//             out_valid/out_ready, result, range_err          (result side)
//  Modports : master - the producer/consumer around the unit
//             slave  - the multiply-reduce unit itself
//  Config   : range_err exists only when MUL_RED_RANGE_CHK_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_red_pipe_if;

    logic        in_valid;
    logic        in_ready;
    logic [23:0] A;             // {A_high, A_low}
    logic [23:0] w;             // {w_high, w_low}
    logic        mul_red_mode;  // 0 = Kyber dual lane, 1 = Dilithium
    logic [1:0]  sel_a;
    logic        out_valid;
    logic        out_ready;
    logic [23:0] result;
`ifdef MUL_RED_RANGE_CHK_EN
    logic        range_err;
`endif

    modport master (
        output in_valid, A, w, mul_red_mode, sel_a, out_ready,
`ifdef MUL_RED_RANGE_CHK_EN
        input  range_err,
`endif
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, A, w, mul_red_mode, sel_a, out_ready,
`ifdef MUL_RED_RANGE_CHK_EN
        output range_err,
`endif
        output in_ready, out_valid, result
    );

endinterface : mul_red_pipe_if

`default_nettype wire

// File: rtl/mul_red_dly.sv
// ============================================================================
//  Module   : mul_red_dly
//  Purpose  : Enable-gated shift-register delay line. q is the value of d
//             sampled DEPTH enabled cycles earlier (DEPTH=0: pass-through).
//  Ports    : clk, rst (async, active-high), en, d[WIDTH], q[WIDTH]
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_red_dly #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 4
) (
    input  wire              clk,
    input  wire              rst,
    input  wire              en,
    input  wire [WIDTH-1:0]  d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign q = d;
        end else begin : g_sr
            logic [WIDTH-1:0] r_sr [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_sr[i] <= '0;
                    end
                end else if (en) begin
                    r_sr[0] <= d;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_sr[i] <= r_sr[i-1];
                    end
                end
            end

            assign q = r_sr[DEPTH-1];
        end
    endgenerate

endmodule : mul_red_dly

`default_nettype wire

// File: rtl/mul_red_pipe.sv
// ============================================================================
//  Module   : mul_red_pipe
//  Purpose  : Stall-capable unified Kyber/Dilithium multiply-reduce unit.
//             Kyber mode   : {A_hi*w_hi mod KQ, A_lo*w_lo mod KQ}
//             Dilithium    : {1'b0, (P1*2^24 + P0*2^12) mod DQ}
//             Latency 3+RED_STAGES advancing cycles, in order, both modes.
//  Ports    : clk, rst (async, active-high)
//             bus : mul_red_pipe_if.slave (valid/ready operand and result)
//  Config   : MUL_RED_RANGE_CHK_EN adds the range_err flag on the bus.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_red_pipe
    import mul_red_pkg::*;
#(
    parameter int KQ         = KQ_DEFAULT,
    parameter int DQ         = DQ_DEFAULT,
    parameter int RED_STAGES = 1,          // 1..3
    parameter int DLY_K4N_AH = 4,
    parameter int DLY_K4N_WH = 5,
    parameter int DLY_K4N_WL = 4,
    parameter int DLY_K4I_AH = 2
) (
    input  wire           clk,
    input  wire           rst,
    mul_red_pipe_if.slave bus
);

    // ------------------------------------------------------------------
    // Global advance: the whole pipe freezes only while a valid result
    // is waiting on a consumer that is not ready.
    // ------------------------------------------------------------------
    logic r_out_valid;
    logic w_en;

    assign w_en         = ~(r_out_valid & ~bus.out_ready);
    assign bus.in_ready = w_en;

    // ------------------------------------------------------------------
    // Operand alignment: delay lines run on every advance, independent of
    // in_valid, so the delayed taps track the operand stream position.
    // ------------------------------------------------------------------
    logic [11:0] w_ah_k4n, w_ah_k4i, w_wh_k4n, w_wl_k4n;

    mul_red_dly #(.WIDTH(12), .DEPTH(DLY_K4N_AH)) u_dly_ah_k4n (
        .clk(clk), .rst(rst), .en(w_en), .d(bus.A[23:12]), .q(w_ah_k4n));
    mul_red_dly #(.WIDTH(12), .DEPTH(DLY_K4I_AH)) u_dly_ah_k4i (
        .clk(clk), .rst(rst), .en(w_en), .d(bus.A[23:12]), .q(w_ah_k4i));
    mul_red_dly #(.WIDTH(12), .DEPTH(DLY_K4N_WH)) u_dly_wh_k4n (
        .clk(clk), .rst(rst), .en(w_en), .d(bus.w[23:12]), .q(w_wh_k4n));
    mul_red_dly #(.WIDTH(12), .DEPTH(DLY_K4N_WL)) u_dly_wl_k4n (
        .clk(clk), .rst(rst), .en(w_en), .d(bus.w[11:0]),  .q(w_wl_k4n));

    logic [11:0] w_ah, w_al, w_wh, w_wl;

    always_comb begin
        w_ah = bus.A[23:12];
        w_al = bus.A[11:0];            // low A half is never delayed
        w_wh = bus.w[23:12];
        w_wl = bus.w[11:0];
        case (sel_e'(bus.sel_a))
            SEL_K4_NTT: begin
                w_ah = w_ah_k4n;
                w_wh = w_wh_k4n;
                w_wl = w_wl_k4n;
            end
            SEL_K4_INTT: w_ah = w_ah_k4i;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // S1: partial products
    // ------------------------------------------------------------------
    logic        r_s1_vld;
    mode_e       r_s1_mode;
    logic [23:0] r_s1_p1, r_s1_p0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_vld  <= 1'b0;
            r_s1_mode <= MODE_KYBER;
            r_s1_p1   <= '0;
            r_s1_p0   <= '0;
        end else if (w_en) begin
            r_s1_vld  <= bus.in_valid;
            r_s1_mode <= mode_e'(bus.mul_red_mode);
            r_s1_p1   <= 24'(w_ah) * 24'(w_wh);
            r_s1_p0   <= 24'(w_al) * 24'(w_wl);
        end
    end

    // ------------------------------------------------------------------
    // S2: Dilithium recombination, Kyber lanes pass through
    // ------------------------------------------------------------------
    logic        r_s2_vld;
    mode_e       r_s2_mode;
    logic [23:0] r_s2_p1, r_s2_p0;
    logic [47:0] r_s2_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_vld  <= 1'b0;
            r_s2_mode <= MODE_KYBER;
            r_s2_p1   <= '0;
            r_s2_p0   <= '0;
            r_s2_s    <= '0;
        end else if (w_en) begin
            r_s2_vld  <= r_s1_vld;
            r_s2_mode <= r_s1_mode;
            r_s2_p1   <= r_s1_p1;
            r_s2_p0   <= r_s1_p0;
            r_s2_s    <= {r_s1_p1, 24'd0} + {12'd0, r_s1_p0, 12'd0};
        end
    end

    // ------------------------------------------------------------------
    // Reduction: residue formed in front of the first reducer register,
    // remaining RED_STAGES-1 registers give the reducers retiming room.
    // ------------------------------------------------------------------
    logic [23:0] w_red;

    assign w_red = (r_s2_mode == MODE_DIL)
                 ? {1'b0, 23'(r_s2_s % 48'(DQ))}
                 : {12'(r_s2_p1 % 24'(KQ)), 12'(r_s2_p0 % 24'(KQ))};

    logic [23:0] r_red_data [RED_STAGES];
    logic        r_red_vld  [RED_STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RED_STAGES; i++) begin
                r_red_data[i] <= '0;
                r_red_vld[i]  <= 1'b0;
            end
        end else if (w_en) begin
            r_red_data[0] <= w_red;
            r_red_vld[0]  <= r_s2_vld;
            for (int i = 1; i < RED_STAGES; i++) begin
                r_red_data[i] <= r_red_data[i-1];
                r_red_vld[i]  <= r_red_vld[i-1];
            end
        end
    end

    // ------------------------------------------------------------------
    // Output register: result only moves on a valid beat, so it holds
    // across bubbles and across stalls.
    // ------------------------------------------------------------------
    logic [23:0] r_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (w_en) begin
            r_out_valid <= r_red_vld[RED_STAGES-1];
            if (r_red_vld[RED_STAGES-1]) begin
                r_result <= r_red_data[RED_STAGES-1];
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;

`ifdef MUL_RED_RANGE_CHK_EN
    // ------------------------------------------------------------------
    // Operand range flag, judged on the operands that actually enter the
    // multipliers and carried alongside the beat.
    // ------------------------------------------------------------------
    logic w_rerr;
    logic r_s1_rerr, r_s2_rerr, r_range_err;
    logic r_red_rerr [RED_STAGES];

    assign w_rerr = (mode_e'(bus.mul_red_mode) == MODE_DIL)
                  ? (({w_ah, w_al} >= 24'(DQ)) | ({w_wh, w_wl} >= 24'(DQ)))
                  : ((w_ah >= 12'(KQ)) | (w_al >= 12'(KQ)) |
                     (w_wh >= 12'(KQ)) | (w_wl >= 12'(KQ)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_rerr   <= 1'b0;
            r_s2_rerr   <= 1'b0;
            r_range_err <= 1'b0;
            for (int i = 0; i < RED_STAGES; i++) begin
                r_red_rerr[i] <= 1'b0;
            end
        end else if (w_en) begin
            r_s1_rerr     <= w_rerr;
            r_s2_rerr     <= r_s1_rerr;
            r_red_rerr[0] <= r_s2_rerr;
            for (int i = 1; i < RED_STAGES; i++) begin
                r_red_rerr[i] <= r_red_rerr[i-1];
            end
            r_range_err   <= r_red_rerr[RED_STAGES-1];
        end
    end

    assign bus.range_err = r_range_err;
`endif

endmodule : mul_red_pipe

`default_nettype wire
